// File: rtl/mipi_csi2_unpack_pkg.sv
// Shared definitions for the CSI-2 packet parser / pixel unpacker.
// Data type codes, parser states, pixel modes and group-size helpers.
package mipi_csi2_pkg;

  localparam logic [5:0] DT_FS    = 6'h00;
  localparam logic [5:0] DT_FE    = 6'h01;
  localparam logic [5:0] DT_RAW8  = 6'h2A;
  localparam logic [5:0] DT_RAW10 = 6'h2B;
  localparam logic [5:0] DT_RAW12 = 6'h2C;

  typedef enum logic [2:0] {
    ST_IDLE, ST_HEADER, ST_PAYLOAD, ST_SKIP, ST_CRC, ST_EOT
  } state_t;

  typedef enum logic [1:0] {MODE_RAW8, MODE_RAW10, MODE_RAW12} mode_t;

  // bytes per unpack group
  function automatic logic [2:0] grp_bytes(mode_t m);
    case (m)
      MODE_RAW10: return 3'd5;
      MODE_RAW12: return 3'd3;
      default:    return 3'd1;
    endcase
  endfunction

  // pixels per unpack group
  function automatic logic [2:0] grp_pix(mode_t m);
    case (m)
      MODE_RAW10: return 3'd4;
      MODE_RAW12: return 3'd2;
      default:    return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/mipi_csi2_pix_unpack.sv
// Byte-to-pixel unpacker with separate collect and emit buffers.
// Ports: clk/resetb (sync, active low), byte_d/byte_we payload byte in,
// mode (RAW8/10/12), flush drops a partial group, clear empties everything.
// pixel/valid: one MSB-aligned pixel per cycle; busy: more pixels follow.
module mipi_csi2_pix_unpack
  import mipi_csi2_pkg::*;
#(
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic [7:0]            byte_d,
  input  logic                  byte_we,
  input  mode_t                 mode,
  input  logic                  flush,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] pixel,
  output logic                  valid,
  output logic                  busy
);

  logic [7:0]  coll [4];
  logic [2:0]  ccnt;
  logic [15:0] g    [4];
  logic [15:0] ebuf [3];
  logic [1:0]  erem;
  logic [15:0] pix_q;
  logic        gdone;

  // Group pixels are built 16 bits wide, MSB-aligned, straight from the
  // collected bytes plus the byte completing the group this cycle.
  always_comb begin
    gdone = byte_we && (ccnt == grp_bytes(mode) - 3'd1);
    for (int i = 0; i < 4; i++) g[i] = '0;
    case (mode)
      MODE_RAW8:  g[0] = {byte_d, 8'h00};
      MODE_RAW10: for (int i = 0; i < 4; i++) g[i] = {coll[i], byte_d[2*i +: 2], 6'h00};
      MODE_RAW12: begin
        g[0] = {coll[0], byte_d[3:0], 4'h0};
        g[1] = {coll[1], byte_d[7:4], 4'h0};
      end
      default: ;
    endcase
  end

  // Emission of one group always finishes before the next one completes
  // (bytes per group >= pixels per group), so the emit buffer never overruns.
  always_ff @(posedge clk) begin
    if (!resetb || clear) begin
      ccnt  <= '0;
      erem  <= '0;
      pix_q <= '0;
      valid <= 1'b0;
      for (int i = 0; i < 4; i++) coll[i] <= '0;
      for (int i = 0; i < 3; i++) ebuf[i] <= '0;
    end else begin
      if (gdone) ccnt <= '0;
      else if (byte_we) begin
        coll[ccnt[1:0]] <= byte_d;
        ccnt            <= ccnt + 3'd1;
      end else if (flush) ccnt <= '0;

      if (gdone) begin
        pix_q   <= g[0];
        valid   <= 1'b1;
        ebuf[0] <= g[1];
        ebuf[1] <= g[2];
        ebuf[2] <= g[3];
        erem    <= 2'(grp_pix(mode) - 3'd1);
      end else if (erem != 2'd0) begin
        pix_q   <= ebuf[0];
        ebuf[0] <= ebuf[1];
        ebuf[1] <= ebuf[2];
        ebuf[2] <= '0;
        erem    <= erem - 2'd1;
        valid   <= 1'b1;
      end else begin
        valid <= 1'b0;
      end
    end
  end

  assign pixel = pix_q[15 -: DATA_WIDTH];
  assign busy  = (erem != 2'd0) || gdone;

endmodule

// File: rtl/mipi_csi2_unpack.sv
// CSI-2 packet parser: header decode, VC filter, frame/line strobes and
// counters around the pixel unpacker.
// Ports: clk/resetb (sync, active low), enable, phy_we/phy_data byte stream,
// vc_en/vc_sel filter, dato/dvo pixel out, lvo/fvo line/frame valid,
// err_short/err_wc error pulses, frame_cnt/line_cnt counters.
module mipi_csi2_unpack
  import mipi_csi2_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  enable,
  input  logic                  phy_we,
  input  logic [7:0]            phy_data,
  input  logic                  vc_en,
  input  logic [1:0]            vc_sel,
  output logic [DATA_WIDTH-1:0] dato,
  output logic                  dvo,
  output logic                  lvo,
  output logic                  fvo,
  output logic                  err_short,
  output logic                  err_wc,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic [CNT_WIDTH-1:0]  line_cnt
);

  state_t      state, state_nxt;
  mode_t       mode, mode_sel;
  logic [1:0]  hcnt;
  logic [7:0]  di;
  logic [15:0] wc;
  logic        crc_cnt;
  logic        line_open, line_more;
  logic        fs_hit, fe_hit, raw_hit, short_err, wc_bad, pix_we, pix_busy;
  logic        vc_rej, is_long;
  state_t      skip_tgt;

  assign vc_rej   = vc_en && (di[7:6] != vc_sel);
  assign is_long  = di[5:0] >= 6'h10;
  assign skip_tgt = (wc == 16'd0) ? ST_CRC : ST_SKIP;
  assign mode_sel = (di[5:0] == DT_RAW10) ? MODE_RAW10 :
                    (di[5:0] == DT_RAW12) ? MODE_RAW12 : MODE_RAW8;

  always_ff @(posedge clk) begin
    if (!resetb) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fs_hit    = 1'b0;
    fe_hit    = 1'b0;
    raw_hit   = 1'b0;
    short_err = 1'b0;
    wc_bad    = 1'b0;
    pix_we    = 1'b0;
    if (!enable) state_nxt = ST_IDLE;
    else case (state)
      ST_IDLE: if (phy_we) state_nxt = ST_HEADER;
      ST_HEADER:
        if (!phy_we) begin
          short_err = 1'b1;
          state_nxt = ST_IDLE;
        end else if (hcnt == 2'd3) begin
          if (vc_rej) state_nxt = is_long ? skip_tgt : ST_EOT;
          else if (di[5:0] == DT_FS) begin
            fs_hit    = 1'b1;
            state_nxt = ST_EOT;
          end else if (di[5:0] == DT_FE) begin
            fe_hit    = 1'b1;
            state_nxt = ST_EOT;
          end else if (!is_long) state_nxt = ST_EOT;
          else if (di[5:0] == DT_RAW8 || di[5:0] == DT_RAW10 || di[5:0] == DT_RAW12) begin
            raw_hit   = 1'b1;
            state_nxt = (wc == 16'd0) ? ST_CRC : ST_PAYLOAD;
            wc_bad    = (di[5:0] == DT_RAW10 && (wc % 16'd5) != 16'd0) ||
                        (di[5:0] == DT_RAW12 && (wc % 16'd3) != 16'd0);
          end else state_nxt = skip_tgt;
        end
      ST_PAYLOAD, ST_SKIP:
        if (!phy_we) begin
          short_err = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          pix_we = (state == ST_PAYLOAD);
          if (wc == 16'd1) state_nxt = ST_CRC;
        end
      ST_CRC:
        if (!phy_we) begin
          short_err = 1'b1;
          state_nxt = ST_IDLE;
        end else if (crc_cnt) state_nxt = ST_EOT;
      ST_EOT: if (!phy_we) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  mipi_csi2_pix_unpack #(.DATA_WIDTH(DATA_WIDTH)) u_unpack (
    .clk     (clk),
    .resetb  (resetb),
    .byte_d  (phy_data),
    .byte_we (pix_we),
    .mode    (mode),
    .flush   (state != ST_PAYLOAD),
    .clear   (!enable),
    .pixel   (dato),
    .valid   (dvo),
    .busy    (pix_busy)
  );

  // The line stays open across gaps between groups as long as pixels are
  // pending or more payload is on its way; it closes after the last pixel.
  assign lvo       = dvo | line_open;
  assign line_more = pix_busy || (state_nxt == ST_PAYLOAD);

  always_ff @(posedge clk) begin
    if (!resetb) begin
      hcnt      <= '0;
      di        <= '0;
      wc        <= '0;
      crc_cnt   <= 1'b0;
      mode      <= MODE_RAW8;
      line_open <= 1'b0;
      fvo       <= 1'b0;
      err_short <= 1'b0;
      err_wc    <= 1'b0;
      frame_cnt <= '0;
      line_cnt  <= '0;
    end else begin
      err_short <= short_err;
      err_wc    <= wc_bad;
      crc_cnt   <= (state == ST_CRC) && phy_we;
      if (!enable) begin
        fvo       <= 1'b0;
        line_open <= 1'b0;
      end else begin
        if (state == ST_IDLE && phy_we) begin
          di   <= phy_data;
          hcnt <= 2'd1;
        end
        if (state == ST_HEADER && phy_we) begin
          hcnt <= hcnt + 2'd1;
          if (hcnt == 2'd1) wc[7:0]  <= phy_data;
          if (hcnt == 2'd2) wc[15:8] <= phy_data;
        end
        if ((state == ST_PAYLOAD || state == ST_SKIP) && phy_we) wc <= wc - 16'd1;
        if (raw_hit) mode <= mode_sel;
        if (fs_hit) fvo <= 1'b1;
        else if (fe_hit) fvo <= 1'b0;
        if (fs_hit) frame_cnt <= frame_cnt + 1'b1;
        line_open <= lvo && line_more;
        if (fs_hit) line_cnt <= '0;
        else if (lvo && !line_more) line_cnt <= line_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mipi_csi2_unpack.sv
module tb_mipi_csi2_unpack;
  localparam int DW = 12;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic          enable = 1'b0;
  logic          phy_we = 1'b0;
  logic [7:0]    phy_data = '0;
  logic          vc_en = 1'b0;
  logic [1:0]    vc_sel = '0;
  logic [DW-1:0] dato;
  logic          dvo, lvo, fvo, err_short, err_wc;
  logic [CW-1:0] frame_cnt, line_cnt;

  mipi_csi2_unpack #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .resetb(resetb), .enable(enable), .phy_we(phy_we),
    .phy_data(phy_data), .vc_en(vc_en), .vc_sel(vc_sel), .dato(dato),
    .dvo(dvo), .lvo(lvo), .fvo(fvo), .err_short(err_short), .err_wc(err_wc),
    .frame_cnt(frame_cnt), .line_cnt(line_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];
  logic [7:0]    pkt[$];
  int line_rises = 0, last_len = 0, cur_len = 0, n_short = 0, n_wc = 0;
  logic lvo_q = 1'b0;

  // scoreboard monitor: every dvo pops and compares one expected pixel
  always @(negedge clk) begin
    if (resetb) begin
      if (dvo) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pix got=%h need=none", dato);
        end else begin
          logic [DW-1:0] e;
          e = exp_q.pop_front();
          if (dato !== e) begin
            bad++;
            $display("FAIL pixel got=%h need=%h", dato, e);
          end
        end
        total++;
        if (lvo !== 1'b1) begin
          bad++;
          $display("FAIL dvo_lvo got lvo=%b need=1", lvo);
        end
      end
      if (lvo) cur_len++;
      if (lvo && !lvo_q) line_rises++;
      if (!lvo && lvo_q) begin
        last_len = cur_len;
        cur_len  = 0;
      end
      if (err_short) n_short++;
      if (err_wc) n_wc++;
      lvo_q = lvo;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h need=%0h", nm, act, exp);
    end
  endtask

  // drive the first n bytes of pkt, drop phy_we, then idle while things drain
  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      phy_we   = 1'b1;
      phy_data = pkt[i];
    end
    @(posedge clk); #1;
    phy_we   = 1'b0;
    phy_data = '0;
    repeat (12) @(posedge clk);
    #2;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      @(posedge clk); #2;
      k++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  initial begin
    // reset
    enable = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("rst_dato", dato, 0);
    chk("rst_strobes", {dvo, lvo, fvo, err_short, err_wc}, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_line_cnt", line_cnt, 0);
    @(posedge clk); #1;
    resetb = 1'b1;
    repeat (2) @(posedge clk);

    // 1: FS then FE
    pkt = {8'h00, 8'h00, 8'h00, 8'h5A};
    send(pkt.size());
    chk("fs_fvo", fvo, 1);
    chk("fs_frame_cnt", frame_cnt, 1);
    chk("fs_line_cnt", line_cnt, 0);
    pkt = {8'h01, 8'h00, 8'h00, 8'h5A};
    send(pkt.size());
    chk("fe_fvo", fvo, 0);
    chk("fe_frame_cnt", frame_cnt, 1);

    // 2: RAW8 WC=4
    exp_q.push_back(12'h110); exp_q.push_back(12'h220);
    exp_q.push_back(12'h330); exp_q.push_back(12'h440);
    pkt = {8'h2A, 8'h04, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hC1, 8'hC2};
    send(pkt.size());
    drain("raw8_drain");
    chk("raw8_line_cnt", line_cnt, 1);
    chk("raw8_lvo_len", last_len, 4);
    chk("raw8_lines", line_rises, 1);

    // 3: RAW10 WC=10, one line of 8 pixels
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(12'h120); exp_q.push_back(12'h344);
      exp_q.push_back(12'h568); exp_q.push_back(12'h78C);
    end
    pkt = {8'h2B, 8'h0A, 8'h00, 8'h00,
           8'h12, 8'h34, 8'h56, 8'h78, 8'hE4,
           8'h12, 8'h34, 8'h56, 8'h78, 8'hE4, 8'hC1, 8'hC2};
    send(pkt.size());
    drain("raw10_drain");
    chk("raw10_line_cnt", line_cnt, 2);
    chk("raw10_lines", line_rises, 2);
    chk("raw10_lvo_len", last_len, 9);

    // 4: RAW12 WC=3 clean, then WC=4 with a trailing partial group
    exp_q.push_back(12'hAB1); exp_q.push_back(12'hCD2);
    pkt = {8'h2C, 8'h03, 8'h00, 8'h00, 8'hAB, 8'hCD, 8'h21, 8'hC1, 8'hC2};
    send(pkt.size());
    drain("raw12_drain");
    chk("raw12_no_err_wc", n_wc, 0);
    exp_q.push_back(12'hAB1); exp_q.push_back(12'hCD2);
    pkt = {8'h2C, 8'h04, 8'h00, 8'h00, 8'hAB, 8'hCD, 8'h21, 8'h55, 8'hC1, 8'hC2};
    send(pkt.size());
    drain("raw12_wc_drain");
    chk("raw12_err_wc", n_wc, 1);
    chk("raw12_line_cnt", line_cnt, 4);

    // 5: VC filter
    vc_en  = 1'b1;
    vc_sel = 2'd1;
    pkt = {8'h2A, 8'h04, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'hC1, 8'hC2};
    send(pkt.size());
    chk("vc_rej_lines", line_rises, 4);
    chk("vc_rej_line_cnt", line_cnt, 4);
    exp_q.push_back(12'h010); exp_q.push_back(12'hFF0);
    pkt = {8'h6A, 8'h02, 8'h00, 8'h00, 8'h01, 8'hFF, 8'hC1, 8'hC2};
    send(pkt.size());
    drain("vc_acc_drain");
    chk("vc_acc_lines", line_rises, 5);
    vc_en = 1'b0;
    chk("no_err_short_yet", n_short, 0);

    // 6: RAW10 truncated after payload byte 7
    exp_q.push_back(12'h120); exp_q.push_back(12'h344);
    exp_q.push_back(12'h568); exp_q.push_back(12'h78C);
    pkt = {8'h2B, 8'h0A, 8'h00, 8'h00,
           8'h12, 8'h34, 8'h56, 8'h78, 8'hE4, 8'h12, 8'h34, 8'h56};
    send(pkt.size());
    drain("short_drain");
    chk("short_err", n_short, 1);
    chk("short_lvo", lvo, 0);
    chk("short_lines", line_rises, 6);
    chk("short_line_cnt", line_cnt, 6);
    pkt = {8'h00, 8'h00, 8'h00, 8'h5A};
    send(pkt.size());
    chk("fs2_fvo", fvo, 1);
    chk("fs2_frame_cnt", frame_cnt, 2);
    chk("fs2_line_cnt", line_cnt, 0);
    chk("final_err_wc", n_wc, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
